// File: rtl/logic_analyzer_capture_ctrl.sv
// Capture sequencer for a sample-RAM logic analyzer: single step, run-to-full and triggered capture.
// Define LA_TRIGGER_EN to build the triggered capture (ARMED/POST); otherwise mode 10 runs as mode 01.
module logic_analyzer_capture_ctrl #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned TRIG_W   = 8,
    parameter int unsigned POST_CNT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_en,
    input  logic              in_init,
    input  logic              stop_n,
    input  logic [1:0]        mode,
    input  logic [TRIG_W-1:0] trig_bus,
    input  logic [TRIG_W-1:0] trig_mask,
    input  logic [TRIG_W-1:0] trig_val,
    output logic              la_run,
    output logic              la_we,
    output logic [ADDR_W-1:0] la_addr,
    output logic              sts_ce,
    output logic              la_full,
    output logic [ADDR_W-1:0] la_trig_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_RUN,
        S_DONE
`ifdef LA_TRIGGER_EN
        , S_ARMED,
        S_POST
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state_q, state_d;
    logic              init_q;
    logic              run_q, run_d;
    logic              full_q, full_d;
    logic              sts_q, sts_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              init_edge;
    logic              step_mode;

`ifdef LA_TRIGGER_EN
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_CNT - 1);

    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic              trig_hit;

    assign trig_hit     = ((trig_bus ^ trig_val) & trig_mask) == '0;
    assign la_trig_addr = trig_addr_q;
`else
    logic unused_trig;

    assign unused_trig  = ^{trig_bus, trig_mask, trig_val};
    assign la_trig_addr = '0;
`endif

    assign init_edge = in_init & ~init_q;
    assign step_mode = (mode == 2'b00) || (mode == 2'b11);
    assign la_we     = run_q & stop_n;
    assign la_run    = run_q;
    assign la_addr   = addr_q;
    assign la_full   = full_q;
    assign sts_ce    = sts_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        full_d  = full_q;
`ifdef LA_TRIGGER_EN
        trig_addr_d = trig_addr_q;
        post_d      = post_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // Any start edge clears the previous capture's results before the new state is chosen.
                if (init_edge) begin
                    addr_d = '0;
                    full_d = 1'b0;
`ifdef LA_TRIGGER_EN
                    trig_addr_d = '0;
`endif
                    if (step_mode)
                        state_d = S_STEP;
`ifdef LA_TRIGGER_EN
                    else if (mode == 2'b10)
                        state_d = S_ARMED;
`endif
                    else
                        state_d = S_RUN;
                end else if ((state_q == S_IDLE) && step_en && step_mode) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: state_d = S_IDLE;
            S_RUN: begin
                if (la_we) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_DONE;
                        full_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef LA_TRIGGER_EN
            S_ARMED: begin
                if (la_we) begin
                    addr_d = addr_q + 1'b1;
                    if (trig_hit) begin
                        trig_addr_d = addr_q;
                        post_d      = '0;
                        state_d     = S_POST;
                    end
                end
            end
            S_POST: begin
                // The final post-trigger write leaves la_addr on the last written sample.
                if (la_we) begin
                    if (post_q == POST_LAST) begin
                        state_d = S_DONE;
                        full_d  = 1'b1;
                    end else begin
                        post_d = post_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef LA_TRIGGER_EN
        run_d = state_d inside {S_STEP, S_RUN, S_ARMED, S_POST};
`else
        run_d = state_d inside {S_STEP, S_RUN};
`endif
        sts_d = run_q & ~run_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            init_q  <= 1'b0;
            run_q   <= 1'b0;
            full_q  <= 1'b0;
            sts_q   <= 1'b0;
            addr_q  <= '0;
`ifdef LA_TRIGGER_EN
            trig_addr_q <= '0;
            post_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= in_init;
            run_q   <= run_d;
            full_q  <= full_d;
            sts_q   <= sts_d;
            addr_q  <= addr_d;
`ifdef LA_TRIGGER_EN
            trig_addr_q <= trig_addr_d;
            post_q      <= post_d;
`endif
        end
    end

endmodule

// File: tb/tb_logic_analyzer_capture_ctrl.sv
// Bench for logic_analyzer_capture_ctrl: directed scenarios plus random stimulus against a
// write-count based reference model.
module tb_logic_analyzer_capture_ctrl;

    localparam int ADDR_W   = 5;
    localparam int TRIG_W   = 8;
    localparam int POST_CNT = 16;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              step_en;
    logic              in_init;
    logic              stop_n;
    logic [1:0]        mode;
    logic [TRIG_W-1:0] trig_bus;
    logic [TRIG_W-1:0] trig_mask;
    logic [TRIG_W-1:0] trig_val;
    logic              la_run;
    logic              la_we;
    logic [ADDR_W-1:0] la_addr;
    logic              sts_ce;
    logic              la_full;
    logic [ADDR_W-1:0] la_trig_addr;

    always #5 clk = ~clk;

    logic_analyzer_capture_ctrl #(
        .ADDR_W  (ADDR_W),
        .TRIG_W  (TRIG_W),
        .POST_CNT(POST_CNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step_en     (step_en),
        .in_init     (in_init),
        .stop_n      (stop_n),
        .mode        (mode),
        .trig_bus    (trig_bus),
        .trig_mask   (trig_mask),
        .trig_val    (trig_val),
        .la_run      (la_run),
        .la_we       (la_we),
        .la_addr     (la_addr),
        .sts_ce      (sts_ce),
        .la_full     (la_full),
        .la_trig_addr(la_trig_addr)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a capture is described by how many samples were written so far and
    // at which write index the trigger fired; addresses follow from those counts.
    int m_prev_init, m_run, m_kind, m_writes, m_trig_idx;
    int m_full, m_done, m_addr, m_trig_addr, m_sts;
    int we_cnt, sts_cnt, run_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_init = 0; m_run = 0; m_kind = 0; m_writes = 0; m_trig_idx = -1;
        m_full = 0; m_done = 0; m_addr = 0; m_trig_addr = 0; m_sts = 0;
    endtask

    task automatic model_step();
        int  eff;
        bit  start_seen;
        bit  finished;
        start_seen  = in_init && (m_prev_init == 0);
        m_prev_init = int'(in_init);
        m_sts       = 0;
        if (m_run != 0) begin
            if (m_kind == 0) begin
                m_run = 0;
                m_sts = 1;
            end else if (stop_n) begin
                if (m_kind == 2 && m_trig_idx < 0 && ((trig_bus ^ trig_val) & trig_mask) == 8'h00) begin
                    m_trig_idx  = m_writes;
                    m_trig_addr = m_writes % DEPTH;
                end
                m_writes++;
                finished = (m_kind == 1 && m_writes == DEPTH) ||
                           (m_kind == 2 && m_trig_idx >= 0 && m_writes == m_trig_idx + 1 + POST_CNT);
                if (finished) begin
                    m_run = 0; m_sts = 1; m_full = 1; m_done = 1;
                    m_addr = (m_writes - 1) % DEPTH;
                end else begin
                    m_addr = m_writes % DEPTH;
                end
            end
        end else begin
            eff = (mode == 2'b11) ? 0 : int'(mode);
`ifndef LA_TRIGGER_EN
            if (eff == 2) eff = 1;
`endif
            if (start_seen) begin
                m_full = 0; m_done = 0; m_addr = 0; m_trig_addr = 0;
                m_writes = 0; m_trig_idx = -1; m_kind = eff; m_run = 1;
            end else if (step_en && eff == 0 && m_done == 0) begin
                m_kind = 0;
                m_run  = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("la_run",       32'(la_run),       32'(m_run));
        check("la_we",        32'(la_we),        32'(m_run) & 32'(stop_n));
        check("la_addr",      32'(la_addr),      32'(m_addr));
        check("sts_ce",       32'(sts_ce),       32'(m_sts));
        check("la_full",      32'(la_full),      32'(m_full));
        check("la_trig_addr", 32'(la_trig_addr), 32'(m_trig_addr));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        compare_outputs();
        if (la_we)  we_cnt++;
        if (sts_ce) sts_cnt++;
        if (la_run) run_cyc++;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic start_capture(input logic [1:0] m);
        mode    = m;
        in_init = 1'b1;
        cycle();
        in_init = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; step_en = 1'b0; in_init = 1'b0; stop_n = 1'b1; mode = 2'b00;
        trig_bus = '0; trig_mask = '0; trig_val = '0;
        we_cnt = 0; sts_cnt = 0; run_cyc = 0;
        model_reset();
        do_reset();
        cycle();

        // Single step, then step together with a start edge, then step_en in mode 01.
        step_en = 1'b1; cycle(); step_en = 1'b0;
        repeat (3) cycle();
        step_en = 1'b1; in_init = 1'b1; cycle(); step_en = 1'b0;
        repeat (3) cycle();
        in_init = 1'b0; cycle();
        mode = 2'b01; step_en = 1'b1; repeat (3) cycle(); step_en = 1'b0;

        // Run to full, with an ignored start edge in the middle.
        we_cnt = 0; sts_cnt = 0;
        start_capture(2'b01);
        for (int i = 0; i < 40; i++) begin
            in_init = (i >= 10 && i < 12);
            cycle();
        end
        check("full_we_count",  32'(we_cnt),  32'd32);
        check("full_sts_count", 32'(sts_cnt), 32'd1);
        check("full_flag",      32'(la_full), 32'd1);
        check("full_addr",      32'(la_addr), 32'd31);

        // Stop for three cycles mid-run: completion moves out by three cycles.
        we_cnt = 0; run_cyc = 0;
        start_capture(2'b01);
        for (int i = 0; i < 45; i++) begin
            stop_n = !(i >= 5 && i < 8);
            cycle();
        end
        stop_n = 1'b1;
        check("stop_run_cycles", 32'(run_cyc), 32'd35);
        check("stop_we_count",   32'(we_cnt),  32'd32);

        // Reset mid-run at address 10, in_init held high across reset release.
        start_capture(2'b01);
        for (int i = 0; i < 40 && m_addr != 10; i++) cycle();
        check("pre_reset_addr", 32'(la_addr), 32'd10);
        in_init = 1'b1;
        do_reset();
        sts_cnt = 0;
        cycle();
        in_init = 1'b0;
        for (int i = 0; i < 40; i++) cycle();
        check("restart_sts_count", 32'(sts_cnt), 32'd1);
        check("restart_addr",      32'(la_addr), 32'd31);

`ifdef LA_TRIGGER_EN
        // Trigger on write 40 (address 8 after one wrap).
        trig_mask = 8'hFF; trig_val = 8'hA5;
        start_capture(2'b10);
        for (int i = 0; i < 70; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            if (r == 8'hA5) r = 8'h5A;
            trig_bus = (m_writes == 40) ? 8'hA5 : r;
            cycle();
        end
        check("trig_addr",       32'(la_trig_addr), 32'd8);
        check("trig_final_addr", 32'(la_addr),      32'd24);
        check("trig_full",       32'(la_full),      32'd1);

        // Empty mask fires on the first write.
        trig_mask = 8'h00;
        start_capture(2'b10);
        for (int i = 0; i < 25; i++) cycle();
        check("zmask_trig_addr",  32'(la_trig_addr), 32'd0);
        check("zmask_final_addr", 32'(la_addr),      32'd16);
`endif

        // Random stimulus.
        for (int ep = 0; ep < 40; ep++) begin
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_reset();
                end
                if (m_run == 0 && m_done != 0)
                    mode = 2'($urandom_range(1, 2));
                else
                    mode = 2'($urandom_range(0, 3));
                step_en   = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) in_init = ~in_init;
                stop_n    = ($urandom_range(0, 4) != 0);
                trig_bus  = 8'($urandom);
                trig_val  = 8'($urandom);
                trig_mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
